// File: rtl/vga_pixel_stream.sv
// Pixel FIFO between an upstream frame reader and the VGA pins.
// Aligns the stream to the first visible pixel of each frame and registers RGB with the delayed sync signals.
module vga_pixel_stream #(
  parameter int FIFO_DEPTH  = 16,
  parameter int COLUMN_BITS = 10,
  parameter int ROW_BITS    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [11:0]            s_pixel,
  input  logic                   s_sof,
  input  logic                   visible,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [COLUMN_BITS-1:0] column,
  input  logic [ROW_BITS-1:0]    row,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   visible_o,
  output logic                   underflow,
  output logic                   desync
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {SYNC_WAIT, ALIGN, STREAM} state_t;

  state_t            state_q, state_d;
  logic [12:0]       mem_q [FIFO_DEPTH];
  logic [12:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hsync_q, vsync_q, visible_q, underflow_q, desync_q;
  logic              underflow_d, desync_d;

  logic        full, empty, push, pop, show, frame_start, head_sof;
  logic [12:0] head;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign s_ready     = !full;
  assign push        = s_valid && !full;
  assign head        = mem_q[rd_ptr_q];
  assign head_sof    = head[12];
  assign frame_start = visible && (column == '0) && (row == '0);

  // Pointers are PTR_W bits wide so they wrap modulo FIFO_DEPTH on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s_sof, s_pixel};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    show        = 1'b0;
    underflow_d = 1'b0;
    desync_d    = 1'b0;
    case (state_q)
      SYNC_WAIT: begin
        if (!empty) begin
          if (head_sof) state_d = ALIGN;
          else          pop     = 1'b1;
        end
      end
      ALIGN: begin
        if (frame_start && !empty) begin
          pop     = 1'b1;
          show    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (visible) begin
          if (empty) begin
            underflow_d = 1'b1;
            state_d     = SYNC_WAIT;
          end else if (frame_start) begin
            if (head_sof) begin
              pop  = 1'b1;
              show = 1'b1;
            end else begin
              desync_d = 1'b1;
              state_d  = SYNC_WAIT;
            end
          end else if (head_sof) begin
            // Upstream started a new frame early: keep its sof pixel for the next frame_start.
            desync_d = 1'b1;
            state_d  = ALIGN;
          end else begin
            pop  = 1'b1;
            show = 1'b1;
          end
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
    rgb_d = (visible && show) ? head[11:0] : 12'h000;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC_WAIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rgb_q       <= 12'h000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      visible_q   <= 1'b0;
      underflow_q <= 1'b0;
      desync_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      visible_q   <= visible;
      underflow_q <= underflow_d;
      desync_q    <= desync_d;
    end
  end

  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;
  assign visible_o = visible_q;
  assign underflow = underflow_q;
  assign desync    = desync_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Self-checking bench for vga_pixel_stream: directed frames with literal expectations, then
// randomized upstream traffic compared every cycle against a queue-based model of the display rules.
module tb_vga_pixel_stream;

  localparam int DEPTH   = 16;
  localparam int H_VIS   = 12;
  localparam int H_TOTAL = 20;
  localparam int V_VIS   = 5;
  localparam int V_TOTAL = 8;
  localparam int FRAME_PIX = H_VIS * V_VIS;

  localparam int HUNT  = 0;
  localparam int ARMED = 1;
  localparam int PLAY  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_ready, s_sof;
  logic [11:0] s_pixel;
  logic       visible, hsync, vsync;
  logic [9:0] column, row;
  logic [3:0] red, green, blue;
  logic       hsync_o, vsync_o, visible_o, underflow, desync;

  vga_pixel_stream #(.FIFO_DEPTH(DEPTH), .COLUMN_BITS(10), .ROW_BITS(10)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_sof(s_sof),
    .visible(visible), .hsync(hsync), .vsync(vsync), .column(column), .row(row),
    .red(red), .green(green), .blue(blue),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .visible_o(visible_o),
    .underflow(underflow), .desync(desync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [12:0] mq[$];
  logic [12:0] script[$];
  int   mmode = HUNT;
  logic [11:0] exp_rgb;
  logic exp_hs, exp_vs, exp_vis, exp_uf, exp_ds;

  int col = 0;
  int row_cnt = V_VIS;
  int fs_seen = 0;
  int lit_pos = 0;
  bit rand_mode = 0;
  bit reset_lit = 0;
  bit did_directed_reset = 0;
  int rate = 97;
  int pix_idx = 0;
  logic [12:0] prod_item;
  int cycles = 0;

  task automatic checkVal(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycles, act, req);
    end
  endtask

  task automatic checkOutput();
    checkVal("rgb", {red, green, blue}, exp_rgb);
    checkVal("hsync_o", 12'(hsync_o), 12'(exp_hs));
    checkVal("vsync_o", 12'(vsync_o), 12'(exp_vs));
    checkVal("visible_o", 12'(visible_o), 12'(exp_vis));
    checkVal("underflow", 12'(underflow), 12'(exp_uf));
    checkVal("desync", 12'(desync), 12'(exp_ds));
    checkVal("s_ready", 12'(s_ready), 12'(mq.size() < DEPTH));
    // Hand-computed expectations pinning the model on the directed frames.
    if (fs_seen == 1) begin
      case (lit_pos)
        0: checkVal("lit_f1_px0", {red, green, blue}, 12'hF00);
        1: checkVal("lit_f1_px1", {red, green, blue}, 12'h0F0);
        2: checkVal("lit_f1_px2", {red, green, blue}, 12'h00F);
        3: checkVal("lit_f1_underflow", 12'(underflow), 12'h001);
        default: ;
      endcase
    end
    if (fs_seen == 2) begin
      case (lit_pos)
        0: checkVal("lit_f2_px0", {red, green, blue}, 12'hABC);
        1: checkVal("lit_f2_px1", {red, green, blue}, 12'h123);
        2: checkVal("lit_f2_px2", {red, green, blue}, 12'h456);
        3: checkVal("lit_f2_underflow", 12'(underflow), 12'h001);
        100: checkVal("lit_full_ready", 12'(s_ready), 12'h000);
        default: ;
      endcase
    end
    if (fs_seen == 3 && lit_pos == 0)
      checkVal("lit_f3_px0", {red, green, blue}, 12'h777);
    if (reset_lit) begin
      reset_lit = 0;
      checkVal("lit_rst_rgb", {red, green, blue}, 12'h000);
      checkVal("lit_rst_sync", {10'd0, hsync_o, vsync_o}, 12'h003);
      checkVal("lit_rst_ready", 12'(s_ready), 12'h001);
      checkVal("lit_rst_underflow", 12'(underflow), 12'h000);
    end
  endtask

  task automatic nextProducerItem();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 99) < 3) pix_idx = 0;
    else pix_idx = (pix_idx + 1) % FRAME_PIX;
    prod_item = {pix_idx == 0, r[11:0]};
  endtask

  task automatic applyStimulus();
    bit fs;
    column  = 10'(col);
    row     = 10'(row_cnt);
    visible = (col < H_VIS) && (row_cnt < V_VIS);
    hsync   = !(col >= 14 && col < 16);
    vsync   = !(row_cnt == 6);
    fs      = visible && col == 0 && row_cnt == 0;
    col++;
    if (col == H_TOTAL) begin
      col = 0;
      row_cnt = (row_cnt + 1) % V_TOTAL;
    end
    if (fs) begin
      fs_seen++;
      lit_pos = 0;
      if (rand_mode) rate = ($urandom_range(0, 3) == 0) ? 30 : 97;
    end else begin
      lit_pos++;
    end

    if (!rand_mode && fs_seen == 1 && lit_pos == 10) begin
      script.push_back({1'b0, 12'h111});
      script.push_back({1'b0, 12'h222});
      script.push_back({1'b0, 12'h333});
      script.push_back({1'b1, 12'hABC});
      script.push_back({1'b0, 12'h123});
      script.push_back({1'b0, 12'h456});
    end
    if (!rand_mode && fs_seen == 2 && lit_pos == 10) begin
      script.push_back({1'b1, 12'h777});
      for (int i = 1; i < 20; i++) script.push_back({1'b0, 12'(12'h700 + i)});
    end
    if (!rand_mode && fs_seen == 3 && lit_pos == 100) begin
      rand_mode = 1;
      pix_idx = 0;
      prod_item = {1'b1, 12'h5A5};
    end

    if (rand_mode && fs_seen == 5 && lit_pos == 30 && !did_directed_reset) begin
      reset = 1'b1;
      did_directed_reset = 1;
      reset_lit = 1;
    end else if (rand_mode && $urandom_range(0, 2999) == 0) begin
      reset = 1'b1;
    end else begin
      reset = 1'b0;
    end

    if (rand_mode) begin
      s_valid = ($urandom_range(0, 99) < rate);
      {s_sof, s_pixel} = prod_item;
    end else begin
      s_valid = (script.size() > 0);
      {s_sof, s_pixel} = (script.size() > 0) ? script[0] : 13'h0;
    end
  endtask

  // Model of the display rules: a plain queue for the FIFO and a mode for frame alignment.
  task automatic modelStep();
    bit fs, push, pop, show;
    if (reset) begin
      mq.delete();
      mmode = HUNT;
      exp_rgb = 12'h000; exp_hs = 1; exp_vs = 1; exp_vis = 0; exp_uf = 0; exp_ds = 0;
      return;
    end
    fs   = visible && column == 0 && row == 0;
    push = s_valid && (mq.size() < DEPTH);
    pop = 0; show = 0; exp_uf = 0; exp_ds = 0;
    case (mmode)
      HUNT: if (mq.size() > 0) begin
        if (mq[0][12]) mmode = ARMED; else pop = 1;
      end
      ARMED: if (fs && mq.size() > 0) begin
        pop = 1; show = 1; mmode = PLAY;
      end
      default: if (visible) begin
        if (mq.size() == 0) begin
          exp_uf = 1; mmode = HUNT;
        end else if (fs) begin
          if (mq[0][12]) begin pop = 1; show = 1; end
          else begin exp_ds = 1; mmode = HUNT; end
        end else if (mq[0][12]) begin
          exp_ds = 1; mmode = ARMED;
        end else begin
          pop = 1; show = 1;
        end
      end
    endcase
    exp_rgb = show ? mq[0][11:0] : 12'h000;
    exp_hs  = hsync;
    exp_vs  = vsync;
    exp_vis = visible;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({s_sof, s_pixel});
      if (rand_mode) nextProducerItem();
      else void'(script.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 0; s_sof = 0; s_pixel = '0;
    visible = 0; hsync = 1; vsync = 1; column = '0; row = '0;
    exp_rgb = 12'h000; exp_hs = 1; exp_vs = 1; exp_vis = 0; exp_uf = 0; exp_ds = 0;
    script.push_back({1'b1, 12'hF00});
    script.push_back({1'b0, 12'h0F0});
    script.push_back({1'b0, 12'h00F});
    repeat (2) @(negedge clk);
    while (fs_seen < 90 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      checkOutput();
      applyStimulus();
      if (cycles <= 2) reset = 1'b1;
      modelStep();
    end
    @(negedge clk);
    checkOutput();
    if (fs_seen < 90) begin
      failures++;
      $display("[TB] FAIL frame_budget: reached %0d frames, expected 90", fs_seen);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
